mem_access_unit: RTL and testbench

- Initiator-side load/store unit that drives the CPU data memory port.
- The data memory port is word-indexed, has a combinational read and a synchronous write. The memory returns wdata on rdata while a write is asserted.
- The unit converts byte addresses to word indices, sign- or zero-extends byte and halfword loads, and performs sub-word stores as read-modify-write.
- Sits between the MEM pipeline stage (valid/ready request, one-cycle response pulse) and the data memory.

---
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-indexed data memory.
// Handles byte-lane extraction, sign/zero extension and sub-word read-modify-write.
module mem_access_unit #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_read_control,
  output logic        write_data_control,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, RMW_READ, WRITE, RESP} state_t;

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  state_t      r_state;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_storeData;
  logic [31:0] r_memWdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_err;
  logic [31:0] w_reqIdx;
  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_loadData;
  logic [31:0] w_laneMask;
  logic [31:0] w_merged;

  assign w_reqIdx = {2'b00, req_addr[31:2]};

  always_comb begin
    w_err = 1'b0;
    if (req_size == 2'd3) w_err = 1'b1;
    if (req_size == 2'd1 && req_addr[0]) w_err = 1'b1;
    if (req_size == 2'd2 && req_addr[1:0] != 2'b00) w_err = 1'b1;
    if (w_reqIdx >= MEM_WORDS_L) w_err = 1'b1;
  end

  // Legal halfwords only sit at offsets 0 or 2, so one byte-offset shift serves both sizes.
  assign w_shamt   = {r_addr[1:0], 3'b000};
  assign w_shifted = mem_rdata >> w_shamt;

  always_comb begin
    w_loadData = mem_rdata;
    case (r_size)
      2'd0:    w_loadData = {{24{r_signed & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_loadData = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_loadData = mem_rdata;
    endcase
  end

  assign w_laneMask = (r_size == 2'd0) ? (32'h0000_00FF << w_shamt)
                                       : (32'h0000_FFFF << w_shamt);
  assign w_merged   = (mem_rdata & ~w_laneMask) | ((r_storeData << w_shamt) & w_laneMask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_size      <= 2'd0;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_storeData <= '0;
      r_memWdata  <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_size      <= req_size;
            r_signed    <= req_signed;
            r_addr      <= req_addr;
            r_storeData <= req_wdata;
            if (w_err) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
              r_state <= RESP;
            end else if (!req_write) begin
              r_state <= READ;
            end else if (req_size == 2'd2) begin
              r_memWdata <= req_wdata;
              r_state    <= WRITE;
            end else begin
              r_state <= RMW_READ;
            end
          end
        end
        READ: begin
          r_rdata <= w_loadData;
          r_err   <= 1'b0;
          r_state <= RESP;
        end
        RMW_READ: begin
          r_memWdata <= w_merged;
          r_state    <= WRITE;
        end
        WRITE: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes and handshakes are decoded from state and masked by reset so an aborted store never writes.
  assign req_ready          = (r_state == IDLE) && !rst;
  assign resp_valid         = (r_state == RESP) && !rst;
  assign mem_read_control   = ((r_state == READ) || (r_state == RMW_READ)) && !rst;
  assign write_data_control = (r_state == WRITE) && !rst;
  assign mem_addr           = (r_state == IDLE) ? '0 : {2'b00, r_addr[31:2]};
  assign mem_wdata          = r_memWdata;
  assign resp_rdata         = r_rdata;
  assign resp_err           = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expectations,
// a monitor checks responses, strobes and latency against a behavioural memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_read_control;
  logic        write_data_control;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] idx;
    logic [31:0] wdata;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] mem[128];
  int          checkCount = 0;
  int          passCount = 0;
  int          cycle = 0;
  int          acceptCycle = 0;
  int          rdCount = 0;
  int          wrCount = 0;

  mem_access_unit #(.MEM_WORDS(128)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_read_control(mem_read_control),
    .write_data_control(write_data_control), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Combinational read with write-through, synchronous write.
  always_comb begin
    if (write_data_control) mem_rdata = mem_wdata;
    else if (mem_addr < 32'd128) mem_rdata = mem[mem_addr[6:0]];
    else mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (write_data_control && mem_addr < 32'd128) mem[mem_addr[6:0]] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic failNote(input string name);
    checkCount++;
    $display("[TB] FAIL %s", name);
  endtask

  always @(posedge clk) begin
    cycle++;
    if (req_valid && req_ready) begin
      acceptCycle = cycle;
      rdCount = 0;
      wrCount = 0;
    end
  end

  // Monitor: strobes are checked against the head expectation, responses pop it.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read_control) begin
        rdCount++;
        if (expQ.size() > 0) checkOutput("read_addr", mem_addr, expQ[0].idx);
      end
      if (write_data_control) begin
        wrCount++;
        if (expQ.size() > 0) begin
          checkOutput("write_addr", mem_addr, expQ[0].idx);
          checkOutput("write_data", mem_wdata, expQ[0].wdata);
        end else begin
          failNote("unexpected_write");
        end
      end
      if (resp_valid) begin
        if (expQ.size() == 0) begin
          failNote("unexpected_resp");
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          checkOutput("latency", 32'(cycle - acceptCycle + 1), 32'(e.lat));
          checkOutput("read_strobes", 32'(rdCount), 32'(e.rd));
          checkOutput("write_strobes", 32'(wrCount), 32'(e.wr));
        end
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expRdata, input logic expErr, input int expLat,
                               input int expRd, input int expWr, input logic [31:0] expWdata);
    exp_t e;
    bit accepted;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    e.rdata = expRdata; e.err = expErr; e.lat = expLat; e.rd = expRd; e.wr = expWr;
    e.idx = {2'b00, addr[31:2]}; e.wdata = expWdata;
    expQ.push_back(e);
    accepted = 0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (req_ready) accepted = 1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_wdata = 32'h5A5A_5A5A;
    req_addr  = 32'hFFFF_FFFC;
    if (!accepted) begin
      failNote("accept_timeout");
      void'(expQ.pop_back());
    end
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      failNote("resp_timeout");
      expQ.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[0] = 32'd1; mem[1] = 32'd1; mem[2] = 32'd5; mem[3] = 32'd4;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'h0);
    checkOutput("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset_resp_err", {31'b0, resp_err}, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_strobes", {30'b0, mem_read_control, write_data_control}, 32'h0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_ready", {31'b0, req_ready}, 32'h1);

    //            wr    size  sgn   addr        wdata          rdata          err  lat rd wr expWdata
    applyStimulus(1'b0, 2'd2, 1'b0, 32'd8,  32'h0,         32'h0000_0005, 1'b0, 2, 1, 0, 32'h0);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'd12, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0, 1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'd12, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1, 0, 32'h0);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'd5,  32'hFFFF_FF80, 32'h0,         1'b0, 3, 1, 1, 32'h0000_8001);
    checkOutput("mem_word1", mem[1], 32'h0000_8001);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'd5,  32'h0,         32'hFFFF_FF80, 1'b0, 2, 1, 0, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'd5,  32'h0,         32'h0000_0080, 1'b0, 2, 1, 0, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'd4,  32'h0,         32'h0000_0001, 1'b0, 2, 1, 0, 32'h0);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'd10, 32'h1234_BEEF, 32'h0,         1'b0, 3, 1, 1, 32'hBEEF_0005);
    checkOutput("mem_word2", mem[2], 32'hBEEF_0005);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'd10, 32'h0,         32'hFFFF_BEEF, 1'b0, 2, 1, 0, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'd10, 32'h0,         32'h0000_BEEF, 1'b0, 2, 1, 0, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'd3,  32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'd512, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'd0,  32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'd2,  32'h1111_1111, 32'h0,         1'b1, 1, 0, 0, 32'h0);

    // Abort a byte store while it is reading the word it will modify.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("rmw_read_strobe", {31'b0, mem_read_control}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("reset_gates_strobes", {30'b0, mem_read_control, write_data_control}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("ready_after_abort", {31'b0, req_ready}, 32'h1);
    repeat (4) @(negedge clk);
    checkOutput("mem_word0_kept", mem[0], 32'h0000_0001);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'd0,  32'h0,         32'h0000_0001, 1'b0, 2, 1, 0, 32'h0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
